// File: rtl/mips_pkg.sv
// Shared pipeline definitions: forwarding-mux select codes, the hazard shadow-slot
// record, and the "slot writes register r" predicate used by the forwarding logic.
package mips_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [REG_ADDR_W_DEF-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_W_DEF-1:0] rd;
    logic                      regwrite;
    logic                      memread;
  } hz_slot_t;

  localparam hz_slot_t HZ_BUBBLE = '0;

  // $0 is hard-wired to zero, so a write to it must never be forwarded.
  function automatic logic slot_writes(input hz_slot_t slot,
                                       input logic [REG_ADDR_W_DEF-1:0] r);
    return slot.valid && slot.regwrite && (slot.rd == r) && (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/fwd_src_sel.sv
// Operand-mux select for one source register: the nearest in-flight producer wins,
// and anything further back is left to the register file's write-before-read.
module fwd_src_sel
  import mips_pkg::*;
(
  input  logic [REG_ADDR_W_DEF-1:0] i_src,
  input  hz_slot_t                  i_ex_slot,
  input  hz_slot_t                  i_mem_slot,
  output logic [1:0]                o_sel
);

  // NOTE: o_sel gets a default first so every path through the block assigns it (no latch).
  always_comb begin
    o_sel = FWD_RF;
    if (slot_writes(i_ex_slot, i_src)) begin
      o_sel = FWD_MEM;
    end else if (slot_writes(i_mem_slot, i_src)) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller; sits beside the ID/EX register and
// advances its shadow slots in lockstep with it.
module fwd_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic                  i_id_regwrite,
  input  logic                  i_id_memread,
  input  logic                  i_flush,
  output logic [1:0]            o_fwd_a,
  output logic [1:0]            o_fwd_b,
  output logic                  o_stall,
  output logic                  o_ex_bubble
);

  // The WB slot has no consumer here: a producer that far ahead reaches EX operands
  // through the register file, so only the EX and MEM slots are stored.
  hz_slot_t   r_ex_slot;
  hz_slot_t   r_mem_slot;
  logic [1:0] r_fwd_a;
  logic [1:0] r_fwd_b;
  logic       r_ex_bubble;

  logic       w_load_in_ex;
  logic       w_stall;
  logic       w_advance;
  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;
  hz_slot_t   w_id_slot;

  assign w_load_in_ex = r_ex_slot.valid && r_ex_slot.memread && r_ex_slot.regwrite &&
                        (r_ex_slot.rd != REG_ZERO);

  // Flush squashes the consumer, so a coincident load-use needs no stall.
  assign w_stall   = i_id_valid && !i_flush && w_load_in_ex &&
                     ((r_ex_slot.rd == i_id_rs) || (r_ex_slot.rd == i_id_rt));
  assign w_advance = i_id_valid && !w_stall && !i_flush;

  assign w_id_slot = '{valid:    1'b1,
                       rd:       i_id_rd,
                       regwrite: i_id_regwrite,
                       memread:  i_id_memread};

  fwd_src_sel u_sel_a (
    .i_src      (i_id_rs),
    .i_ex_slot  (r_ex_slot),
    .i_mem_slot (r_mem_slot),
    .o_sel      (w_sel_a)
  );

  fwd_src_sel u_sel_b (
    .i_src      (i_id_rt),
    .i_ex_slot  (r_ex_slot),
    .i_mem_slot (r_mem_slot),
    .o_sel      (w_sel_b)
  );

  // NOTE: sequential state uses non-blocking assignments so every slot samples its pre-edge value.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ex_slot   <= HZ_BUBBLE;
      r_mem_slot  <= HZ_BUBBLE;
      r_fwd_a     <= FWD_RF;
      r_fwd_b     <= FWD_RF;
      r_ex_bubble <= 1'b1;
    end else begin
      r_mem_slot <= r_ex_slot;
      if (w_advance) begin
        r_ex_slot   <= w_id_slot;
        r_fwd_a     <= w_sel_a;
        r_fwd_b     <= w_sel_b;
        r_ex_bubble <= 1'b0;
      end else begin
        r_ex_slot   <= HZ_BUBBLE;
        r_fwd_a     <= FWD_RF;
        r_fwd_b     <= FWD_RF;
        r_ex_bubble <= 1'b1;
      end
    end
  end

  assign o_fwd_a     = r_fwd_a;
  assign o_fwd_b     = r_fwd_b;
  assign o_stall     = w_stall;
  assign o_ex_bubble = r_ex_bubble;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed test-plan sequences followed by
// random instruction streams, checked against a history-of-issued-instructions model.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_id_valid;
  logic [4:0] i_id_rs, i_id_rt, i_id_rd;
  logic       i_id_regwrite, i_id_memread, i_flush;
  logic [1:0] o_fwd_a, o_fwd_b;
  logic       o_stall, o_ex_bubble;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_ADDR_W(5)) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_id_valid    (i_id_valid),
    .i_id_rs       (i_id_rs),
    .i_id_rt       (i_id_rt),
    .i_id_rd       (i_id_rd),
    .i_id_regwrite (i_id_regwrite),
    .i_id_memread  (i_id_memread),
    .i_flush       (i_flush),
    .o_fwd_a       (o_fwd_a),
    .o_fwd_b       (o_fwd_b),
    .o_stall       (o_stall),
    .o_ex_bubble   (o_ex_bubble)
  );

  // Model: the instructions that entered EX on the last two edges, newest first.
  // hist[0] is the instruction now in EX (one ahead of ID), hist[1] is two ahead.
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
  } instr_t;

  instr_t hist[2];
  int     exp_a, exp_b, exp_bub;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit produces(input instr_t e, input int r);
    return e.v && e.rw && (e.rd == r) && (r != 0);
  endfunction

  function automatic int nearest_src(input int r);
    if (produces(hist[0], r)) return 1;
    if (produces(hist[1], r)) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    hist[0] = '{0, 0, 0, 0};
    hist[1] = '{0, 0, 0, 0};
    exp_a   = 0;
    exp_b   = 0;
    exp_bub = 1;
  endtask

  // Called one time unit after a rising edge; leaves the bench at the same phase.
  task automatic step(input bit v, input int rs, input int rt, input int rd,
                      input bit rw, input bit mr, input bit fl, input bit rst);
    bit exp_stall, adv;
    i_id_valid    = v;
    i_id_rs       = rs[4:0];
    i_id_rt       = rt[4:0];
    i_id_rd       = rd[4:0];
    i_id_regwrite = rw;
    i_id_memread  = mr;
    i_flush       = fl;
    i_reset       = rst;
    #1;
    exp_stall = v && !fl && hist[0].mr &&
                (produces(hist[0], rs) || produces(hist[0], rt));
    check("stall", o_stall, exp_stall);
    adv = v && !exp_stall && !fl;
    if (rst) begin
      model_reset();
    end else begin
      exp_a   = adv ? nearest_src(rs) : 0;
      exp_b   = adv ? nearest_src(rt) : 0;
      exp_bub = adv ? 0 : 1;
      hist[1] = hist[0];
      hist[0] = adv ? '{1, rd, rw, mr} : '{0, 0, 0, 0};
    end
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    check("fwd_a", o_fwd_a, exp_a);
    check("fwd_b", o_fwd_b, exp_b);
    check("bubble", o_ex_bubble, exp_bub);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    i_reset = 1'b1; i_id_valid = 0; i_id_rs = 0; i_id_rt = 0; i_id_rd = 0;
    i_id_regwrite = 0; i_id_memread = 0; i_flush = 0;
    @(posedge clk);
    #1;
    model_reset();
    i_reset = 1'b0;
    #1;
    check("rst_fwd_a", o_fwd_a, 0);
    check("rst_fwd_b", o_fwd_b, 0);
    check("rst_bubble", o_ex_bubble, 1);
    check("rst_stall", o_stall, 0);

    // add $3 ; sub using $3 as rs
    step(1, 1, 2, 3, 1, 0, 0, 0);
    step(1, 3, 4, 5, 1, 0, 0, 0);
    check("tp_ex_fwd_a", o_fwd_a, 2'b01);
    check("tp_ex_fwd_b", o_fwd_b, 2'b00);

    // producer $3, independent, consumer of $3 on rt
    step(1, 1, 2, 3, 1, 0, 0, 0);
    step(1, 1, 2, 6, 1, 0, 0, 0);
    step(1, 7, 3, 8, 1, 0, 0, 0);
    check("tp_wb_fwd_b", o_fwd_b, 2'b10);
    // two producers of $3 in a row: nearest wins
    step(1, 1, 2, 3, 1, 0, 0, 0);
    step(1, 1, 2, 3, 1, 0, 0, 0);
    step(1, 7, 3, 8, 1, 0, 0, 0);
    check("tp_near_fwd_b", o_fwd_b, 2'b01);

    // lw $5 ; add using $5: one stall, bubble, then select 10
    step(1, 1, 2, 5, 1, 1, 0, 0);
    step(1, 5, 1, 9, 1, 0, 0, 0);
    check("tp_lu_bubble", o_ex_bubble, 1);
    step(1, 5, 1, 9, 1, 0, 0, 0);
    check("tp_lu_fwd_a", o_fwd_a, 2'b10);
    check("tp_lu_bubble2", o_ex_bubble, 0);

    // writes to $0, and a non-writing instruction with matching rd
    step(1, 1, 2, 0, 1, 1, 0, 0);
    step(1, 0, 0, 4, 0, 1, 0, 0);
    check("tp_zero_a", o_fwd_a, 2'b00);
    step(1, 4, 4, 10, 1, 0, 0, 0);
    check("tp_norw_b", o_fwd_b, 2'b00);

    // load-use coinciding with flush
    step(1, 1, 2, 6, 1, 1, 0, 0);
    step(1, 6, 6, 11, 1, 0, 1, 0);
    check("tp_fl_bubble", o_ex_bubble, 1);
    check("tp_fl_fwd_a", o_fwd_a, 2'b00);

    // reset mid-stream with a load in EX
    step(1, 1, 2, 7, 1, 1, 0, 0);
    step(1, 7, 7, 12, 1, 0, 0, 1);
    check("tp_rst_bubble", o_ex_bubble, 1);
    step(1, 7, 7, 12, 1, 0, 0, 0);
    check("tp_rst_fwd_a", o_fwd_a, 2'b00);
    idle();

    // random streams over a small register set to provoke dependencies
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 7) != 0,
           $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
